eight_bit_select_subtractor: RTL and testbench

Pipelined 8-bit borrow-select subtractor computing A − B − Bin, the inverse datapath to the team's pipelined carry-select adder. It sits beside the adder in the arithmetic block so that add/subtract round-trips (A + B − B) can be checked in simulation. The low nibble resolves the borrow in one stage while both high-nibble candidates are precomputed, and the final stage selects between them. A valid bit travels with the data, and a global enable stalls the whole pipe.

---
 rtl/eight_bit_select_subtractor.sv | 139 +++++++++++++
 tb/tb_eight_bit_select_subtractor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/eight_bit_select_subtractor.sv
// rtl/eight_bit_select_subtractor.sv - pipelined 8-bit borrow-select subtractor
//
// Purpose:
//    Computes (A - B - Bin) mod 256 and the borrow-out over three pipeline
//    stages: input register, low-nibble subtract with both high-nibble
//    candidates precomputed, and final borrow select. A valid bit travels
//    with the data; en = 0 freezes every stage.
//
// Optional feature:
//    SUB_OVF_EN - when defined, output_ovf reports signed overflow aligned
//                 with output_diff; when undefined, output_ovf is tied to 0.
//
// Ports:
//    clk          in   rising-edge clock
//    reset_n      in   asynchronous active-low reset
//    en           in   pipeline advance (0 = all stages hold)
//    in_valid     in   A/B/Bin qualify this cycle
//    A            in   [7:0] minuend, unsigned
//    B            in   [7:0] subtrahend, unsigned
//    Bin          in   borrow-in
//    output_diff  out  [7:0] (A - B - Bin) mod 256
//    output_Bout  out  borrow-out, 1 when A < B + Bin
//    output_ovf   out  signed overflow (SUB_OVF_EN builds only, else 0)
//    out_valid    out  outputs qualify this cycle

module eight_bit_select_subtractor (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en,
   input  logic       in_valid,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       Bin,
   output logic [7:0] output_diff,
   output logic       output_Bout,
   output logic       output_ovf,
   output logic       out_valid
);

   // Stage 0: input register
   logic [7:0] a_q;
   logic [7:0] b_q;
   logic       bin_q;
   logic       v0_q;

   // Stage 1: low nibble result plus both high-nibble candidates.
   // Candidates are {borrow_out, nibble}.
   logic [3:0] d_lo_q,  d_lo_d;
   logic       b4_q,    b4_d;
   logic [4:0] hi0_q,   hi0_d;
   logic [4:0] hi1_q,   hi1_d;
   logic       v1_q;

   // Stage 2: selected result
   logic [7:0] diff_q,  diff_d;
   logic       bout_q,  bout_d;
   logic       v2_q;

   logic [4:0] lo_full;
   logic [4:0] hi_sel;

   always_comb begin
      lo_full = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0000, bin_q};
      d_lo_d  = lo_full[3:0];
      b4_d    = lo_full[4];
      // Bit 4 of a 5-bit difference is the borrow out of the nibble.
      hi0_d   = {1'b0, a_q[7:4]} - {1'b0, b_q[7:4]};
      hi1_d   = {1'b0, a_q[7:4]} - {1'b0, b_q[7:4]} - 5'd1;
   end

   always_comb begin
      hi_sel = b4_q ? hi1_q : hi0_q;
      diff_d = {hi_sel[3:0], d_lo_q};
      bout_d = hi_sel[4];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q    <= 8'h00;
         b_q    <= 8'h00;
         bin_q  <= 1'b0;
         v0_q   <= 1'b0;
         d_lo_q <= 4'h0;
         b4_q   <= 1'b0;
         hi0_q  <= 5'h00;
         hi1_q  <= 5'h00;
         v1_q   <= 1'b0;
         diff_q <= 8'h00;
         bout_q <= 1'b0;
         v2_q   <= 1'b0;
      end else if (en) begin
         // Data registers load even on bubbles; only the valid bit matters.
         a_q    <= A;
         b_q    <= B;
         bin_q  <= Bin;
         v0_q   <= in_valid;
         d_lo_q <= d_lo_d;
         b4_q   <= b4_d;
         hi0_q  <= hi0_d;
         hi1_q  <= hi1_d;
         v1_q   <= v0_q;
         diff_q <= diff_d;
         bout_q <= bout_d;
         v2_q   <= v1_q;
      end
   end

   assign output_diff = diff_q;
   assign output_Bout = bout_q;
   assign out_valid   = v2_q;

`ifdef SUB_OVF_EN
   // Operand sign bits ride along stage 1 so the flag lines up with diff.
   logic a7_q;
   logic b7_q;
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = (a7_q != b7_q) && (hi_sel[3] != a7_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a7_q  <= 1'b0;
         b7_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else if (en) begin
         a7_q  <= a_q[7];
         b7_q  <= b_q[7];
         ovf_q <= ovf_d;
      end
   end

   assign output_ovf = ovf_q;
`else
   assign output_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_eight_bit_select_subtractor.sv
// tb/tb_eight_bit_select_subtractor.sv - directed bench for eight_bit_select_subtractor

module tb_eight_bit_select_subtractor;

   logic       clk;
   logic       reset_n;
   logic       en;
   logic       in_valid;
   logic [7:0] A;
   logic [7:0] B;
   logic       Bin;
   logic [7:0] output_diff;
   logic       output_Bout;
   logic       output_ovf;
   logic       out_valid;

   eight_bit_select_subtractor dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .en          (en),
      .in_valid    (in_valid),
      .A           (A),
      .B           (B),
      .Bin         (Bin),
      .output_diff (output_diff),
      .output_Bout (output_Bout),
      .output_ovf  (output_ovf),
      .out_valid   (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
      logic       ovf;    // expected flag when the overflow feature is built
   } vec_t;

   typedef struct {
      logic       vld;
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
   } exp_t;

   vec_t vecs[14];
   exp_t exp_q[$];

   int n_vec  = 0;
   int n_fail = 0;

`ifdef SUB_OVF_EN
   localparam bit OVF_BUILT = 1'b1;
`else
   localparam bit OVF_BUILT = 1'b0;
`endif

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
      exp_t       e;
      logic [8:0] s;
      s      = {1'b0, a} + {1'b0, ~b} + {8'h00, ~bin};
      e.vld  = 1'b1;
      e.diff = s[7:0];
      e.bout = ~s[8];
      e.ovf  = OVF_BUILT && (a[7] != b[7]) && (s[7] != a[7]);
      return e;
   endfunction

   task automatic check_out(input string name, input exp_t e);
      n_vec++;
      if (out_valid !== e.vld ||
          (e.vld && (output_diff !== e.diff || output_Bout !== e.bout || output_ovf !== e.ovf))) begin
         n_fail++;
         $display("FAIL %s: got vld=%b diff=%h bout=%b ovf=%b, want vld=%b diff=%h bout=%b ovf=%b",
                  name, out_valid, output_diff, output_Bout, output_ovf,
                  e.vld, e.diff, e.bout, e.ovf);
      end
   endtask

   // Called at a negedge: retire the result three edges old, drive the next op.
   task automatic step(input string name, input logic vld, input logic [7:0] a,
                       input logic [7:0] b, input logic bin, input exp_t e);
      exp_t x;
      if (exp_q.size() == 3) begin
         x = exp_q.pop_front();
         check_out(name, x);
      end
      en       = 1'b1;
      in_valid = vld;
      A        = a;
      B        = b;
      Bin      = bin;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      exp_t bub;
      bub = '{vld: 1'b0, diff: 8'h00, bout: 1'b0, ovf: 1'b0};
      for (int i = 0; i < 3; i++) step(name, 1'b0, 8'h00, 8'h00, 1'b0, bub);
      exp_q.delete();
   endtask

   initial begin
      exp_t e;
      exp_t zero_e;
      zero_e = '{vld: 1'b0, diff: 8'h00, bout: 1'b0, ovf: 1'b0};

      //            a      b      bin  diff   bout  ovf
      vecs[0]  = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
      vecs[1]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      vecs[2]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
      vecs[3]  = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
      vecs[4]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[5]  = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[6]  = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
      vecs[7]  = '{8'h5A, 8'h5A, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[8]  = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[9]  = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[10] = '{8'h3C, 8'h0F, 1'b1, 8'h2C, 1'b0, 1'b0};
      vecs[11] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b1};
      vecs[12] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
      vecs[13] = '{8'h12, 8'h34, 1'b0, 8'hDE, 1'b1, 1'b0};

      reset_n  = 1'b0;
      en       = 1'b0;
      in_valid = 1'b0;
      A        = 8'h00;
      B        = 8'h00;
      Bin      = 1'b0;
      repeat (2) @(negedge clk);
      check_out("reset_state", zero_e);
      // out_valid=0 alone does not cover data; check data explicitly too.
      n_vec++;
      if (output_diff !== 8'h00 || output_Bout !== 1'b0 || output_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_data: got diff=%h bout=%b ovf=%b, want 00 0 0",
                  output_diff, output_Bout, output_ovf);
      end
      reset_n = 1'b1;
      @(negedge clk);

      // Directed table, back-to-back
      for (int i = 0; i < 14; i++) begin
         e.vld  = 1'b1;
         e.diff = vecs[i].diff;
         e.bout = vecs[i].bout;
         e.ovf  = OVF_BUILT & vecs[i].ovf;
         step($sformatf("table_%0d", i), 1'b1, vecs[i].a, vecs[i].b, vecs[i].bin, e);
      end
      drain("table_drain");

      // Sweep: every A against a spread of B values, both borrow-ins
      for (int bin = 0; bin < 2; bin++)
         for (int b = 0; b < 256; b += 15)
            for (int a = 0; a < 256; a++)
               step("sweep", 1'b1, 8'(a), 8'(b), 1'(bin), model(8'(a), 8'(b), 1'(bin)));
      drain("sweep_drain");

      // Bubbles: alternate valid 1/0
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0)
            step("bubble", 1'b1, 8'(i * 9), 8'(i * 5), 1'b0, model(8'(i * 9), 8'(i * 5), 1'b0));
         else
            step("bubble", 1'b0, 8'hAA, 8'h55, 1'b1, zero_e);
      end
      drain("bubble_drain");

      // Stall with three ops in flight
      step("stall_fill", 1'b1, 8'h05, 8'h03, 1'b0, zero_e);
      step("stall_fill", 1'b1, 8'h80, 8'h01, 1'b0, zero_e);
      step("stall_fill", 1'b1, 8'h00, 8'h01, 1'b0, zero_e);
      exp_q.delete();
      check_out("stall_op1", model(8'h05, 8'h03, 1'b0));
      for (int i = 0; i < 4; i++) begin
         en       = 1'b0;
         in_valid = 1'b1;
         A        = 8'(8'h11 * i + 8'h33);
         B        = 8'hC3;
         Bin      = 1'(i);
         @(posedge clk);
         @(negedge clk);
         check_out("stall_frozen", model(8'h05, 8'h03, 1'b0));
      end
      en       = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      check_out("stall_op2", model(8'h80, 8'h01, 1'b0));
      @(posedge clk); @(negedge clk);
      check_out("stall_op3", model(8'h00, 8'h01, 1'b0));
      @(posedge clk); @(negedge clk);
      check_out("stall_no_dup", zero_e);

      // Reset mid-flight
      step("rst_fill", 1'b1, 8'h44, 8'h22, 1'b0, zero_e);
      step("rst_fill", 1'b1, 8'h10, 8'h01, 1'b0, zero_e);
      step("rst_fill", 1'b1, 8'h99, 8'h11, 1'b1, zero_e);
      exp_q.delete();
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || output_diff !== 8'h00 || output_Bout !== 1'b0 || output_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got vld=%b diff=%h bout=%b ovf=%b, want all 0",
                  out_valid, output_diff, output_Bout, output_ovf);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); @(negedge clk);
         check_out("post_reset_idle", zero_e);
      end
      step("post_reset_op", 1'b1, 8'h7F, 8'hFF, 1'b0, model(8'h7F, 8'hFF, 1'b0));
      step("post_reset_op", 1'b0, 8'h00, 8'h00, 1'b0, zero_e);
      step("post_reset_op", 1'b0, 8'h00, 8'h00, 1'b0, zero_e);
      step("post_reset_op", 1'b0, 8'h00, 8'h00, 1'b0, zero_e);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
